// File: rtl/nios2_cordic_ocimem_pkg.sv
//==============================================================================
// Module   : nios2_cordic_ocimem_pkg
// Purpose  : Shared types and default widths for the OCI RAM arbiter slice.
//            Holds the grant encoding, the JTAG operation code and the
//            JTAG command state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package nios2_cordic_ocimem_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int OCI_DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_JTAG = 2'd2
    } grant_e;

    typedef enum logic {
        JOP_RD = 1'b0,
        JOP_WR = 1'b1
    } jop_e;

    typedef enum logic [1:0] {
        JIDLE = 2'd0,
        JPEND = 2'd1,
        JRD   = 2'd2
    } jstate_e;

endpackage

`default_nettype wire

// File: rtl/nios2_cordic_ocimem_jtag_cmd.sv
//==============================================================================
// Module   : nios2_cordic_ocimem_jtag_cmd
// Purpose  : JTAG side of the OCI RAM arbiter. Keeps the auto-incrementing
//            address pointer, the one-entry pending command register, the
//            sticky overrun flag and the mon_ready/mon_dreg state machine.
// Ports    : clk_i/reset_i       - clock, asynchronous active-high reset
//            set_addr_i/write_i/read_i, addr_i, wdata_i - JTAG strobes
//            gnt_i               - pending command owns the RAM this cycle
//            ram_rdata_i         - RAM read data (one cycle after address)
//            req_o/req_we_o/req_addr_o/req_wdata_o - request to the arbiter
//            mon_dreg_o/mon_ready_o/overrun_o      - registered status
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nios2_cordic_ocimem_jtag_cmd
    import nios2_cordic_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              set_addr_i,
    input  logic              write_i,
    input  logic              read_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              gnt_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              req_o,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic [DATA_W-1:0] mon_dreg_o,
    output logic              mon_ready_o,
    output logic              overrun_o
);

    jstate_e           state_q;
    jop_e              op_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mon_dreg_q;
    logic              mon_ready_q;
    logic              overrun_q;

    logic [ADDR_W-1:0] w_base;
    logic              w_strobe;
    logic              w_accept;

    // A coincident set_addr redirects the operation itself, not only the
    // pointer, so the op address is taken from the load value.
    always_comb begin
        w_base   = set_addr_i ? addr_i : ptr_q;
        w_strobe = read_i | write_i;
        w_accept = w_strobe & mon_ready_q;
        ptr_d    = w_accept ? (w_base + ADDR_W'(1)) : w_base;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= JIDLE;
            op_q        <= JOP_RD;
            ptr_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mon_dreg_q  <= '0;
            mon_ready_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (w_strobe && !mon_ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                JIDLE: begin
                    if (w_accept) begin
                        state_q     <= JPEND;
                        op_q        <= write_i ? JOP_WR : JOP_RD;
                        addr_q      <= w_base;
                        wdata_q     <= wdata_i;
                        mon_ready_q <= 1'b0;
                    end
                end
                JPEND: begin
                    if (gnt_i) begin
                        if (op_q == JOP_WR) begin
                            state_q     <= JIDLE;
                            mon_ready_q <= 1'b1;
                        end else begin
                            state_q <= JRD;
                        end
                    end
                end
                JRD: begin
                    // RAM data for the address granted last cycle is valid now.
                    mon_dreg_q  <= ram_rdata_i;
                    state_q     <= JIDLE;
                    mon_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= JIDLE;
                    mon_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_o       = (state_q == JPEND);
    assign req_we_o    = (op_q == JOP_WR);
    assign req_addr_o  = addr_q;
    assign req_wdata_o = wdata_q;
    assign mon_dreg_o  = mon_dreg_q;
    assign mon_ready_o = mon_ready_q;
    assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: rtl/nios2_cordic_cpu_ocimem_arbiter.sv
//==============================================================================
// Module   : nios2_cordic_cpu_ocimem_arbiter
// Purpose  : Shares the single-port OCI RAM between the JTAG command path
//            and the CPU Avalon debug slave, one access per cycle with
//            alternating priority on contention.
// Ports    : clk_i/reset_i - clock, asynchronous active-high reset
//            jtag_*_i      - JTAG strobes, pointer value and write data
//            mon_dreg_o, mon_ready_o, jtag_overrun_o - JTAG status
//            cpu_*         - Avalon slave (waitrequest/readdatavalid)
//            ram_*         - external synchronous single-port RAM
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nios2_cordic_cpu_ocimem_arbiter
    import nios2_cordic_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              jtag_set_addr_i,
    input  logic              jtag_write_i,
    input  logic              jtag_read_i,
    input  logic [ADDR_W-1:0] jtag_addr_i,
    input  logic [DATA_W-1:0] jtag_wdata_i,
    output logic [DATA_W-1:0] mon_dreg_o,
    output logic              mon_ready_o,
    output logic              jtag_overrun_o,
    input  logic [ADDR_W-1:0] cpu_address_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [DATA_W-1:0] cpu_writedata_i,
    output logic              cpu_waitrequest_o,
    output logic [DATA_W-1:0] cpu_readdata_o,
    output logic              cpu_readdatavalid_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    logic              w_jreq;
    logic              w_jwe;
    logic [ADDR_W-1:0] w_jaddr;
    logic [DATA_W-1:0] w_jwdata;
    logic              w_cpu_req;
    grant_e            w_grant;

    grant_e            last_grant_q;
    logic              rdv_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_wdata;

    nios2_cordic_ocimem_jtag_cmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_cmd (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .set_addr_i  (jtag_set_addr_i),
        .write_i     (jtag_write_i),
        .read_i      (jtag_read_i),
        .addr_i      (jtag_addr_i),
        .wdata_i     (jtag_wdata_i),
        .gnt_i       (w_grant == GNT_JTAG),
        .ram_rdata_i (ram_rdata_i),
        .req_o       (w_jreq),
        .req_we_o    (w_jwe),
        .req_addr_o  (w_jaddr),
        .req_wdata_o (w_jwdata),
        .mon_dreg_o  (mon_dreg_o),
        .mon_ready_o (mon_ready_o),
        .overrun_o   (jtag_overrun_o)
    );

    assign w_cpu_req = cpu_read_i | cpu_write_i;

    // The grant is gated by reset so that a CPU request held across reset
    // cannot reach the RAM or be acknowledged while the block is in reset.
    always_comb begin
        w_grant = GNT_NONE;
        if (!reset_i) begin
            if (w_jreq && w_cpu_req) begin
                w_grant = (last_grant_q == GNT_JTAG) ? GNT_CPU : GNT_JTAG;
            end else if (w_jreq) begin
                w_grant = GNT_JTAG;
            end else if (w_cpu_req) begin
                w_grant = GNT_CPU;
            end
        end
    end

    // Without a grant the address and data buses hold their last value so
    // the RAM inputs do not toggle on idle cycles.
    always_comb begin
        w_ram_addr  = ram_addr_q;
        w_ram_we    = 1'b0;
        w_ram_wdata = ram_wdata_q;
        case (w_grant)
            GNT_JTAG: begin
                w_ram_addr  = w_jaddr;
                w_ram_we    = w_jwe;
                w_ram_wdata = w_jwdata;
            end
            GNT_CPU: begin
                w_ram_addr  = cpu_address_i;
                w_ram_we    = cpu_write_i;
                w_ram_wdata = cpu_writedata_i;
            end
            default: begin
                w_ram_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant_q <= GNT_CPU;
            rdv_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            // A simultaneous read+write from the CPU is a write: no read beat.
            rdv_q <= (w_grant == GNT_CPU) && !cpu_write_i;
            if (w_grant != GNT_NONE) begin
                last_grant_q <= w_grant;
                ram_addr_q   <= w_ram_addr;
                ram_wdata_q  <= w_ram_wdata;
            end
        end
    end

    assign ram_addr_o          = w_ram_addr;
    assign ram_we_o            = w_ram_we;
    assign ram_wdata_o         = w_ram_wdata;
    assign cpu_waitrequest_o   = (w_grant != GNT_CPU);
    assign cpu_readdata_o      = ram_rdata_i;
    assign cpu_readdatavalid_o = rdv_q;

endmodule

`default_nettype wire

// File: tb/tb_nios2_cordic_cpu_ocimem_arbiter.sv
//==============================================================================
// Module   : tb_nios2_cordic_cpu_ocimem_arbiter
// Purpose  : Directed self-checking bench for the OCI RAM arbiter, with a
//            behavioural synchronous single-port RAM attached.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nios2_cordic_cpu_ocimem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          jtag_set_addr, jtag_write, jtag_read;
    logic [AW-1:0] jtag_addr;
    logic [DW-1:0] jtag_wdata;
    logic [DW-1:0] mon_dreg;
    logic          mon_ready, jtag_overrun;
    logic [AW-1:0] cpu_address;
    logic          cpu_read, cpu_write;
    logic [DW-1:0] cpu_writedata;
    logic          cpu_waitrequest;
    logic [DW-1:0] cpu_readdata;
    logic          cpu_readdatavalid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    nios2_cordic_cpu_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .jtag_set_addr_i     (jtag_set_addr),
        .jtag_write_i        (jtag_write),
        .jtag_read_i         (jtag_read),
        .jtag_addr_i         (jtag_addr),
        .jtag_wdata_i        (jtag_wdata),
        .mon_dreg_o          (mon_dreg),
        .mon_ready_o         (mon_ready),
        .jtag_overrun_o      (jtag_overrun),
        .cpu_address_i       (cpu_address),
        .cpu_read_i          (cpu_read),
        .cpu_write_i         (cpu_write),
        .cpu_writedata_i     (cpu_writedata),
        .cpu_waitrequest_o   (cpu_waitrequest),
        .cpu_readdata_o      (cpu_readdata),
        .cpu_readdatavalid_o (cpu_readdatavalid),
        .ram_addr_o          (ram_addr),
        .ram_we_o            (ram_we),
        .ram_wdata_o         (ram_wdata),
        .ram_rdata_i         (ram_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_jtag();
        jtag_set_addr = 1'b0;
        jtag_write    = 1'b0;
        jtag_read     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_chk++; if (mon_dreg !== 32'h0) $display("FAIL rst_mon_dreg got %h want 0", mon_dreg); else n_pass++;
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL rst_mon_ready got %b want 1", mon_ready); else n_pass++;
        n_chk++; if (jtag_overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", jtag_overrun); else n_pass++;
        n_chk++; if (cpu_waitrequest !== 1'b1) $display("FAIL rst_waitreq got %b want 1", cpu_waitrequest); else n_pass++;
        n_chk++; if (cpu_readdatavalid !== 1'b0) $display("FAIL rst_rdv got %b want 0", cpu_readdatavalid); else n_pass++;
        n_chk++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got %b want 0", ram_we); else n_pass++;
        n_chk++; if (ram_addr !== 8'h00) $display("FAIL rst_ram_addr got %h want 00", ram_addr); else n_pass++;
        n_chk++; if (ram_wdata !== 32'h0) $display("FAIL rst_ram_wdata got %h want 0", ram_wdata); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_jtag_write_read();
        jtag_set_addr = 1'b1; jtag_addr = 8'h10; jtag_write = 1'b1; jtag_wdata = 32'hDEADBEEF;
        step();                                  // E0: write captured
        clear_jtag();
        #1;
        n_chk++; if (mon_ready !== 1'b0) $display("FAIL wr_ready_low got %b want 0", mon_ready); else n_pass++;
        n_chk++; if (ram_we !== 1'b1) $display("FAIL wr_ram_we got %b want 1", ram_we); else n_pass++;
        n_chk++; if (ram_addr !== 8'h10) $display("FAIL wr_ram_addr got %h want 10", ram_addr); else n_pass++;
        n_chk++; if (ram_wdata !== 32'hDEADBEEF) $display("FAIL wr_ram_wdata got %h want deadbeef", ram_wdata); else n_pass++;
        step();                                  // E1: committed
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL wr_ready_e1 got %b want 1", mon_ready); else n_pass++;
        n_chk++; if (mem[8'h10] !== 32'hDEADBEEF) $display("FAIL wr_mem10 got %h want deadbeef", mem[8'h10]); else n_pass++;

        jtag_set_addr = 1'b1; jtag_addr = 8'h10; jtag_read = 1'b1;
        step();                                  // E0: read captured
        clear_jtag();
        #1;
        n_chk++; if (ram_we !== 1'b0 || ram_addr !== 8'h10) $display("FAIL rd_ram_drive got we=%b addr=%h want we=0 addr=10", ram_we, ram_addr); else n_pass++;
        step();                                  // E1
        n_chk++; if (mon_ready !== 1'b0) $display("FAIL rd_ready_e1 got %b want 0", mon_ready); else n_pass++;
        step();                                  // E2
        n_chk++; if (mon_dreg !== 32'hDEADBEEF) $display("FAIL rd_mon_dreg got %h want deadbeef", mon_dreg); else n_pass++;
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL rd_ready_e2 got %b want 1", mon_ready); else n_pass++;
        n_chk++; if (cpu_readdatavalid !== 1'b0) $display("FAIL rd_no_cpu_rdv got %b want 0", cpu_readdatavalid); else n_pass++;

        jtag_read = 1'b1;                        // pointer must now be 0x11
        step();
        clear_jtag();
        #1;
        n_chk++; if (ram_addr !== 8'h11) $display("FAIL rd_ptr_inc got %h want 11", ram_addr); else n_pass++;
        step();
        step();
    endtask

    task automatic test_cpu_burst();
        for (int i = 0; i < 8; i++) begin
            cpu_write = 1'b1; cpu_address = 8'(i); cpu_writedata = 32'hA5A50000 + i;
            #1;
            n_chk++; if (cpu_waitrequest !== 1'b0) $display("FAIL cpu_wr_wait[%0d] got %b want 0", i, cpu_waitrequest); else n_pass++;
            step();
        end
        cpu_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_read = 1'b1; cpu_address = 8'(i);
            #1;
            n_chk++; if (cpu_waitrequest !== 1'b0) $display("FAIL cpu_rd_wait[%0d] got %b want 0", i, cpu_waitrequest); else n_pass++;
            if (i == 0) begin
                n_chk++; if (cpu_readdatavalid !== 1'b0) $display("FAIL cpu_rdv_after_wr got %b want 0", cpu_readdatavalid); else n_pass++;
            end else begin
                n_chk++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'hA5A50000 + i - 1)
                    $display("FAIL cpu_beat[%0d] got v=%b d=%h want v=1 d=%h", i - 1, cpu_readdatavalid, cpu_readdata, 32'hA5A50000 + i - 1); else n_pass++;
            end
            step();
        end
        cpu_read = 1'b0;
        #1;
        n_chk++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'hA5A50007)
            $display("FAIL cpu_beat[7] got v=%b d=%h want v=1 d=a5a50007", cpu_readdatavalid, cpu_readdata); else n_pass++;
        step();
        n_chk++; if (cpu_readdatavalid !== 1'b0) $display("FAIL cpu_rdv_end got %b want 0", cpu_readdatavalid); else n_pass++;
    endtask

    task automatic test_contention();
        cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'h12345678;
        step();
        cpu_address = 8'h05; cpu_writedata = 32'h0BADF00D;
        step();
        cpu_write = 1'b0;
        reset = 1'b1;                            // last_grant back to CPU
        step();
        reset = 1'b0;
        step();

        // Tie with last_grant=CPU: JTAG first, CPU waits one cycle.
        jtag_set_addr = 1'b1; jtag_addr = 8'h20; jtag_read = 1'b1;
        step();                                  // E0
        clear_jtag();
        cpu_read = 1'b1; cpu_address = 8'h05;
        #1;
        n_chk++; if (cpu_waitrequest !== 1'b1 || ram_addr !== 8'h20) $display("FAIL tie1_jtag_first got wait=%b addr=%h want wait=1 addr=20", cpu_waitrequest, ram_addr); else n_pass++;
        step();                                  // E1
        n_chk++; if (cpu_waitrequest !== 1'b0 || ram_addr !== 8'h05) $display("FAIL tie1_cpu_next got wait=%b addr=%h want wait=0 addr=05", cpu_waitrequest, ram_addr); else n_pass++;
        step();                                  // E2
        cpu_read = 1'b0;
        #1;
        n_chk++; if (mon_ready !== 1'b1 || mon_dreg !== 32'h12345678) $display("FAIL tie1_mon got r=%b d=%h want r=1 d=12345678", mon_ready, mon_dreg); else n_pass++;
        n_chk++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'h0BADF00D) $display("FAIL tie1_cpu_data got v=%b d=%h want v=1 d=0badf00d", cpu_readdatavalid, cpu_readdata); else n_pass++;
        step();

        // JTAG-only write leaves last_grant=JTAG, so the next tie goes to CPU.
        jtag_set_addr = 1'b1; jtag_addr = 8'h30; jtag_write = 1'b1; jtag_wdata = 32'h00000055;
        step();
        clear_jtag();
        step();
        jtag_set_addr = 1'b1; jtag_addr = 8'h31; jtag_write = 1'b1; jtag_wdata = 32'h00000066;
        step();                                  // E0
        clear_jtag();
        cpu_read = 1'b1; cpu_address = 8'h30;
        #1;
        n_chk++; if (cpu_waitrequest !== 1'b0 || ram_addr !== 8'h30) $display("FAIL tie2_cpu_first got wait=%b addr=%h want wait=0 addr=30", cpu_waitrequest, ram_addr); else n_pass++;
        step();                                  // E1
        cpu_read = 1'b0;
        #1;
        n_chk++; if (ram_we !== 1'b1 || ram_addr !== 8'h31) $display("FAIL tie2_jtag_next got we=%b addr=%h want we=1 addr=31", ram_we, ram_addr); else n_pass++;
        n_chk++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'h55) $display("FAIL tie2_cpu_data got v=%b d=%h want v=1 d=55", cpu_readdatavalid, cpu_readdata); else n_pass++;
        step();
        n_chk++; if (mon_ready !== 1'b1 || mem[8'h31] !== 32'h66) $display("FAIL tie2_jtag_done got r=%b m=%h want r=1 m=66", mon_ready, mem[8'h31]); else n_pass++;
    endtask

    task automatic test_addr_wrap();
        jtag_set_addr = 1'b1; jtag_addr = 8'hFF; jtag_write = 1'b1; jtag_wdata = 32'h1;
        step();
        clear_jtag();
        step();
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL wrap_ready got %b want 1", mon_ready); else n_pass++;
        jtag_write = 1'b1; jtag_wdata = 32'h2;
        step();
        clear_jtag();
        step();
        n_chk++; if (mem[8'hFF] !== 32'h1) $display("FAIL wrap_memFF got %h want 1", mem[8'hFF]); else n_pass++;
        n_chk++; if (mem[8'h00] !== 32'h2) $display("FAIL wrap_mem00 got %h want 2", mem[8'h00]); else n_pass++;
    endtask

    task automatic test_overrun();
        jtag_set_addr = 1'b1; jtag_addr = 8'h40; jtag_write = 1'b1; jtag_wdata = 32'hCAFEF00D;
        step();
        clear_jtag();
        step();
        n_chk++; if (jtag_overrun !== 1'b0) $display("FAIL ovr_clean got %b want 0", jtag_overrun); else n_pass++;
        jtag_set_addr = 1'b1; jtag_addr = 8'h40; jtag_read = 1'b1;
        step();                                  // E0
        clear_jtag();
        jtag_read = 1'b1;                        // arrives while busy
        step();                                  // E1
        clear_jtag();
        n_chk++; if (jtag_overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", jtag_overrun); else n_pass++;
        step();                                  // E2
        n_chk++; if (mon_ready !== 1'b1 || mon_dreg !== 32'hCAFEF00D) $display("FAIL ovr_first_rd got r=%b d=%h want r=1 d=cafef00d", mon_ready, mon_dreg); else n_pass++;
        jtag_read = 1'b1;
        step();
        clear_jtag();
        #1;
        n_chk++; if (ram_addr !== 8'h41) $display("FAIL ovr_ptr got %h want 41", ram_addr); else n_pass++;
        step();
        step();
        n_chk++; if (jtag_overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", jtag_overrun); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        cpu_read = 1'b1; cpu_address = 8'h07;
        jtag_set_addr = 1'b1; jtag_addr = 8'h50; jtag_read = 1'b1;
        #1;
        n_chk++; if (cpu_waitrequest !== 1'b0) $display("FAIL rmo_cpu_grant got %b want 0", cpu_waitrequest); else n_pass++;
        step();                                  // E0: JTAG pending, CPU read in flight
        clear_jtag();
        reset = 1'b1;
        #1;
        n_chk++; if (cpu_readdatavalid !== 1'b0) $display("FAIL rmo_rdv got %b want 0", cpu_readdatavalid); else n_pass++;
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL rmo_ready got %b want 1", mon_ready); else n_pass++;
        n_chk++; if (ram_we !== 1'b0 || ram_addr !== 8'h00) $display("FAIL rmo_ram got we=%b addr=%h want we=0 addr=00", ram_we, ram_addr); else n_pass++;
        n_chk++; if (cpu_waitrequest !== 1'b1) $display("FAIL rmo_wait got %b want 1", cpu_waitrequest); else n_pass++;
        step();
        step();
        n_chk++; if (cpu_readdatavalid !== 1'b0 || ram_we !== 1'b0) $display("FAIL rmo_hold got rdv=%b we=%b want 0 0", cpu_readdatavalid, ram_we); else n_pass++;
        reset = 1'b0;
        cpu_read = 1'b0;
        step();
        n_chk++; if (cpu_readdatavalid !== 1'b0 || mon_ready !== 1'b1 || jtag_overrun !== 1'b0)
            $display("FAIL rmo_release got rdv=%b r=%b ovr=%b want 0 1 0", cpu_readdatavalid, mon_ready, jtag_overrun); else n_pass++;
        jtag_read = 1'b1;
        step();
        clear_jtag();
        #1;
        n_chk++; if (ram_addr !== 8'h00) $display("FAIL rmo_ptr got %h want 00", ram_addr); else n_pass++;
        step();
        step();
        n_chk++; if (mon_ready !== 1'b1) $display("FAIL rmo_final_ready got %b want 1", mon_ready); else n_pass++;
    endtask

    initial begin
        reset         = 1'b1;
        clear_jtag();
        jtag_addr     = '0;
        jtag_wdata    = '0;
        cpu_address   = '0;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_writedata = '0;

        test_reset();
        test_jtag_write_read();
        test_cpu_burst();
        test_contention();
        test_addr_wrap();
        test_overrun();
        test_reset_mid_op();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
